// File: rtl/ychip_run_ctrl.sv
// Run controller and trace FIFO for yChip: entry-point load, counted/free/single-step execution.
// Optional YCHIP_TRACE_WRAP_EN: a push into a full trace FIFO overwrites the oldest entry instead of being dropped.
module ychip_run_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             INT,
    input  logic             start,
    input  logic             step,
    input  logic             halt_req,
    input  logic [WIDTH-1:0] entry_point,
    input  logic [CNT_W-1:0] run_count,
    input  logic [WIDTH-1:0] ins,
    input  logic [WIDTH-1:0] rd2,
    input  logic [WIDTH-1:0] wb,
    output logic             chip_int,
    output logic [WIDTH-1:0] chip_entry,
    output logic             chip_en,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] exec_count,
    input  logic             tr_rd_en,
    output logic             tr_valid,
    output logic [WIDTH-1:0] tr_ins,
    output logic [WIDTH-1:0] tr_rd2,
    output logic [WIDTH-1:0] tr_wb,
    output logic             overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic             counted;
    logic             exec;
    logic             last_cnt;

    logic [3*WIDTH-1:0] mem [DEPTH];
    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic               empty;
    logic               full;
    logic               push;
    logic               pop;
    logic               wr_adv;
    logic               rd_adv;
    logic               lost;

    assign last_cnt = counted && (remaining == CNT_W'(1));

    always_comb begin
        state_nxt = state;
        exec      = 1'b0;
        chip_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                chip_en   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                chip_en = 1'b1;
                exec    = 1'b1;
                // The final counted instruction takes priority over a halt request.
                if (last_cnt)      state_nxt = S_DONE;
                else if (halt_req) state_nxt = S_PAUSE;
            end
            S_PAUSE: begin
                if (start) begin
                    state_nxt = S_RUN;
                end else if (step) begin
                    chip_en = 1'b1;
                    exec    = 1'b1;
                    if (last_cnt) state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (INT) begin
            state      <= S_IDLE;
            chip_int   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            chip_entry <= '0;
            remaining  <= '0;
            counted    <= 1'b0;
            exec_count <= '0;
        end else begin
            state    <= state_nxt;
            chip_int <= (state_nxt == S_LOAD);
            busy     <= (state_nxt != S_IDLE);
            done     <= (state_nxt == S_DONE);
            if (state == S_IDLE && start) begin
                chip_entry <= entry_point;
                remaining  <= run_count;
                counted    <= (run_count != '0);
                exec_count <= '0;
            end else if (exec) begin
                if (counted) remaining <= remaining - CNT_W'(1);
                if (exec_count != '1) exec_count <= exec_count + CNT_W'(1);
            end
        end
    end

    // Trace FIFO: pointers carry a wrap bit so full and empty are distinguishable.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push  = exec;
    assign pop   = tr_rd_en && !empty;
    assign lost  = push && full && !pop;

`ifdef YCHIP_TRACE_WRAP_EN
    assign wr_adv = push;
    assign rd_adv = pop || (push && full);
`else
    assign wr_adv = push && (!full || pop);
    assign rd_adv = pop;
`endif

    always_ff @(posedge clk) begin
        if (INT) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_adv) wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_adv) rd_ptr <= rd_ptr + PTR_ONE;
            if (state == S_IDLE && start) overflow <= 1'b0;
            else if (lost)                overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_adv) mem[wr_ptr[AW-1:0]] <= {ins, rd2, wb};
    end

    assign tr_valid = !empty;
    assign {tr_ins, tr_rd2, tr_wb} = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_ychip_run_ctrl.sv
// Directed bench for ychip_run_ctrl: scoreboard queue of expected trace entries, immediate-assertion checks.
module tb_ychip_run_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             INT;
    logic             start;
    logic             step;
    logic             halt_req;
    logic [WIDTH-1:0] entry_point;
    logic [CNT_W-1:0] run_count;
    logic [WIDTH-1:0] ins;
    logic [WIDTH-1:0] rd2;
    logic [WIDTH-1:0] wb;
    logic             chip_int;
    logic [WIDTH-1:0] chip_entry;
    logic             chip_en;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] exec_count;
    logic             tr_rd_en;
    logic             tr_valid;
    logic [WIDTH-1:0] tr_ins;
    logic [WIDTH-1:0] tr_rd2;
    logic [WIDTH-1:0] tr_wb;
    logic             overflow;

    ychip_run_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .INT(INT), .start(start), .step(step), .halt_req(halt_req),
        .entry_point(entry_point), .run_count(run_count),
        .ins(ins), .rd2(rd2), .wb(wb),
        .chip_int(chip_int), .chip_entry(chip_entry), .chip_en(chip_en),
        .busy(busy), .done(done), .exec_count(exec_count),
        .tr_rd_en(tr_rd_en), .tr_valid(tr_valid),
        .tr_ins(tr_ins), .tr_rd2(tr_rd2), .tr_wb(tr_wb), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int              checks   = 0;
    int              failures = 0;
    int              cyc      = 0;
    logic [95:0]     sb_q[$];
    logic            ovf_exp  = 1'b0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; new chip observation data is applied just after each edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        ins = 32'hA500_0000 ^ (cyc * 32'h0000_9E37);
        rd2 = cyc * 3 + 7;
        wb  = ~cyc;
    endtask

    // Model of the trace FIFO contents: pop (if reading) happens before the push.
    task automatic sb_push(input logic [95:0] e);
        logic [95:0] tmp;
        if (sb_q.size() >= DEPTH) begin
            ovf_exp = 1'b1;
`ifdef YCHIP_TRACE_WRAP_EN
            tmp = sb_q.pop_front();
            sb_q.push_back(e);
`endif
        end else begin
            sb_q.push_back(e);
        end
    endtask

    task automatic run_cycle(input bit ex, input bit rd);
        logic [95:0] e;
        #1;
        if (rd) begin
            chk("tr_valid_rd", tr_valid, 1'b1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("tr_head", {tr_ins, tr_rd2, tr_wb}, e);
            end else begin
                chk("sb_empty_on_read", 1'b1, 1'b0 ^ tr_valid ^ tr_valid);
            end
            tr_rd_en = 1'b1;
        end
        if (ex) begin
            chk("chip_en_exec", chip_en, 1'b1);
            sb_push({ins, rd2, wb});
        end
        tick();
        tr_rd_en = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = sb_q.size();
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b1);
        #1;
        chk("tr_valid_drained", tr_valid, 1'b0);
    endtask

    task automatic do_start(input logic [WIDTH-1:0] ep, input logic [CNT_W-1:0] rc);
        entry_point = ep;
        run_count   = rc;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("load_chip_int", chip_int, 1'b1);
        chk("load_chip_en", chip_en, 1'b1);
        chk("load_chip_entry", chip_entry, ep);
        chk("load_busy", busy, 1'b1);
        chk("load_exec_count", exec_count, 0);
        chk("load_overflow", overflow, 1'b0);
        ovf_exp = 1'b0;
        tick();
        chk("run_chip_int", chip_int, 1'b0);
    endtask

    task automatic finish_run(input int n);
        chk("done_pulse", done, 1'b1);
        chk("done_exec_count", exec_count, n);
        chk("done_overflow", overflow, ovf_exp);
        tick();
        chk("done_clear", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
    endtask

    task automatic reset_dut();
        INT = 1'b1;
        tick();
        INT = 1'b0;
        sb_q.delete();
        ovf_exp = 1'b0;
        chk("rst_busy", busy, 1'b0);
        chk("rst_chip_en", chip_en, 1'b0);
        chk("rst_chip_int", chip_int, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tr_valid", tr_valid, 1'b0);
        chk("rst_exec_count", exec_count, 0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_tr_data", {tr_ins, tr_rd2, tr_wb}, 96'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        INT = 1'b1; start = 1'b0; step = 1'b0; halt_req = 1'b0; tr_rd_en = 1'b0;
        entry_point = '0; run_count = '0; ins = '0; rd2 = '0; wb = '0;
        tick();
        tick();
        chk("rst_chip_entry", chip_entry, 0);
        reset_dut();

        // Pop while empty is ignored
        tr_rd_en = 1'b1;
        tick();
        tr_rd_en = 1'b0;
        chk("pop_empty_valid", tr_valid, 1'b0);
        chk("pop_empty_busy", busy, 1'b0);

        // Counted run of 10
        do_start(32'h28, 16'd10);
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("run_no_done", done, 1'b0);
            run_cycle(1'b1, 1'b0);
        end
        finish_run(10);
        drain();

        // Overflow: 43 instructions into a 16-entry FIFO
        do_start(32'h100, 16'd43);
        for (int i = 0; i < 43; i++) run_cycle(1'b1, 1'b0);
        chk("ovf_exp_model", ovf_exp, 1'b1);
        finish_run(43);
        drain();

        // Free run, halt at 5th cycle, 3 steps, resume
        do_start(32'h200, 16'd0);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b0);
        halt_req = 1'b1;
        run_cycle(1'b1, 1'b0);
        halt_req = 1'b0;
        #1;
        chk("pause_chip_en", chip_en, 1'b0);
        chk("pause_exec_count", exec_count, 5);
        chk("pause_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step = 1'b1;
            run_cycle(1'b1, 1'b0);
            step = 1'b0;
            #1;
            chk("pause_idle_chip_en", chip_en, 1'b0);
            run_cycle(1'b0, 1'b0);
        end
        chk("steps_exec_count", exec_count, 8);
        start = 1'b1;
        step  = 1'b1;
        #1;
        chk("start_beats_step", chip_en, 1'b0);
        run_cycle(1'b0, 1'b0);
        start = 1'b0;
        step  = 1'b0;
        chk("resume_exec_count", exec_count, 8);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        chk("resume_exec_count2", exec_count, 11);
        chk("resume_no_done", done, 1'b0);
        chk("resume_busy", busy, 1'b1);
        reset_dut();

        // Counted run of 6: halt after 4, two steps reach DONE
        do_start(32'h300, 16'd6);
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b0);
        halt_req = 1'b1;
        run_cycle(1'b1, 1'b0);
        halt_req = 1'b0;
        chk("step_pause_count", exec_count, 4);
        step = 1'b1;
        run_cycle(1'b1, 1'b0);
        step = 1'b0;
        chk("step1_count", exec_count, 5);
        chk("step1_no_done", done, 1'b0);
        chk("step1_busy", busy, 1'b1);
        step = 1'b1;
        run_cycle(1'b1, 1'b0);
        step = 1'b0;
        finish_run(6);
        drain();

        // Full FIFO with a read every cycle: no loss
        do_start(32'h400, 16'd20);
        for (int i = 0; i < 16; i++) run_cycle(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) run_cycle(1'b1, 1'b1);
        chk("pushpop_overflow", overflow, 1'b0);
        finish_run(20);
        drain();

        // INT mid-run at exec_count 7
        do_start(32'h500, 16'd0);
        for (int i = 0; i < 7; i++) run_cycle(1'b1, 1'b0);
        chk("pre_int_count", exec_count, 7);
        chk("pre_int_valid", tr_valid, 1'b1);
        reset_dut();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ychip_run_ctrl.md
# ychip_run_ctrl

Parametrised run controller and trace buffer for `yChip`. It replaces fixed-count bench sequencing with hardware:
- loads an entry point through the chip's `INT` input;
- runs a programmed number of instructions, free-runs, or single-steps;
- records `{ins, rd2, wb}` for each executed instruction in a FIFO that a host or bench drains.

It sits between the host/bench and `yChip`, gating the chip's execution through a clock enable.

## Interface
- `WIDTH`, default 32: width of data and instruction (`ins`, `rd2`, `wb`, `entry_point`).
- `DEPTH`, default 16: number of trace FIFO entries. Must be a power of two, at least 2.
- `CNT_W`, default 16: width of `run_count` and `exec_count`.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `INT`  in  1  reset; synchronous, active-high; clears all state.
- `start`  in  1  begin a run from IDLE, or resume free-run from PAUSE.
- `step`  in  1  in PAUSE, execute exactly one instruction.
- `halt_req`  in  1  in RUN, stop after the current cycle and enter PAUSE.
- `entry_point`  in  WIDTH  PC value loaded at start; sampled when `start` is accepted in IDLE.
- `run_count`  in  CNT_W  instructions to execute; sampled with `entry_point`; 0 means free-run.
- `ins`, `rd2`, `wb`  in  WIDTH each  chip observation signals; valid during any cycle with `chip_en`=1.
- `chip_int`  out  1  drive to `yChip` `INT`; entry-point load strobe.
- `chip_entry`  out  WIDTH  drive to `yChip` `entryPoint`.
- `chip_en`  out  1  chip execute enable; one instruction commits per cycle high.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse on completion of a counted run.
- `exec_count`  out  CNT_W  instructions executed since the last accepted `start` from IDLE.
- `tr_rd_en`  in  1  pop the trace head.
- `tr_valid`  out  1  FIFO not empty.
- `tr_ins`, `tr_rd2`, `tr_wb`  out  WIDTH each  trace head; first-word-fall-through.
- `overflow`  out  1  sticky flag: at least one trace entry was lost or overwritten. Cleared by `INT` or by `start` from IDLE.

## Operation
- States: IDLE, LOAD, RUN, PAUSE, DONE.
- **IDLE**
  - `start`=1 → LOAD.
  - Latches `entry_point` into `chip_entry` and `run_count` into `remaining`.
  - Clears `exec_count` and `overflow`.
  - Does not clear the FIFO.
- **LOAD**
  - `chip_int`=1 and `chip_en`=1 for exactly one cycle; the chip loads its PC.
  - Nothing is executed or traced in this cycle.
  - Next state is RUN.
- **RUN**
  - `chip_en`=1 every cycle.
  - Each RUN cycle pushes `{ins, rd2, wb}` and increments `exec_count`.
  - For a counted run, `remaining` decrements each cycle. The cycle with `remaining`=1 is the last executed cycle; next state is DONE.
  - If `halt_req`=1, the current cycle still executes, then next state is PAUSE.
  - If `halt_req` and the last counted cycle coincide, DONE wins.
- **PAUSE**
  - `chip_en`=0.
  - `step`=1 executes one cycle (`chip_en`=1, push, count, decrement), then remains in PAUSE. If that step consumes the last counted instruction, next state is DONE.
  - `start`=1 → RUN.
  - If `start` and `step` are both high, `start` wins.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `exec_count` saturates at all-ones.
- **FIFO**
  - Read and write pointers are `log2(DEPTH)+1` bits with wrap bit; full/empty are derived from the pointers.
  - A push and pop in the same cycle are always legal, including when full; in that case there is no loss.
  - A pop when empty is ignored.
  - A push when full without a pop follows the configuration below.
- **`INT` mid-operation**: on the next edge the state is IDLE, the FIFO is empty, and all counters and flags are 0. Any in-progress run is discarded.

## Timing
- Reset values:
  - `chip_int`=0, `chip_en`=0, `chip_entry`=0.
  - `busy`=0, `done`=0, `exec_count`=0.
  - `tr_valid`=0, `tr_*`=0, `overflow`=0.
- `start` accepted at edge N → LOAD during cycle N+1 → first RUN cycle at N+2.
- A counted run of K instructions: `chip_en` is high for K+1 cycles (LOAD plus K RUN cycles). `done` is asserted K+2 cycles after the accepting edge.
- A trace entry pushed at edge E is visible on `tr_valid`/`tr_*` during cycle E+1.
- `done`, `chip_int`, and `busy` are registered outputs.

## Configuration
- `YCHIP_TRACE_WRAP_EN`
  - Defined: a push when full overwrites the oldest entry. The read pointer advances with the write, so the FIFO retains the newest DEPTH entries. Sets `overflow`.
  - Undefined: a push when full is dropped, so the FIFO retains the oldest DEPTH entries. Sets `overflow`.

## Test plan
- **Counted run.** `entry_point`=0x28, `run_count`=10, pulse `start`, no reads.
  - One `chip_int` cycle with `chip_entry`=0x28, then `chip_en` for 10 RUN cycles.
  - `done` pulses once; `exec_count`=10; 10 trace entries match the chip's `ins`/`rd2`/`wb` in order; `overflow`=0.
- **Overflow.** `run_count`=43 with DEPTH=16, no reads.
  - `exec_count`=43 and `overflow`=1.
  - Without the macro, FIFO holds instructions 1–16. With `YCHIP_TRACE_WRAP_EN`, it holds instructions 28–43.
- **Halt and step.** Free-run (`run_count`=0); assert `halt_req` at the 5th RUN cycle; then 3 `step` pulses; then `start`.
  - `exec_count`=5 in PAUSE, then 8 after the steps; RUN resumes and no `done` is asserted.
- **Step into DONE.** `run_count`=6, halt after 4, then 2 steps.
  - The second step leads to DONE; `done` pulses; `exec_count`=6.
- **Simultaneous push and pop.** FIFO full, reading every cycle during RUN.
  - `overflow` stays 0 and the FIFO stays full with no loss.
- **Reset mid-run.** Assert `INT` for 1 cycle during RUN at `exec_count`=7.
  - Next cycle: IDLE, `busy`=0, `chip_en`=0, `tr_valid`=0, `exec_count`=0, `overflow`=0.
